// File: rtl/fifo_prefetch_filler.sv
// Burst read prefetcher that fills a synchronous FIFO using credit-based flow control.
// Define PREFETCH_OVF_CHECK_EN to add the sticky ovf_err output and its checking logic.
module fifo_prefetch_filler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int FIFO_DEPTH      = 9,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_flush,
  output logic                  busy,
  output logic                  done,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_rstfifo,
  input  logic                  fifo_pop,
  input  logic                  fifo_full
`ifdef PREFETCH_OVF_CHECK_EN
  ,
  output logic                  ovf_err
`endif
);

  // state  | meaning
  // IDLE   | waiting for cfg_start / cfg_flush
  // BURST  | issuing read requests while credits and outstanding slots allow
  // DRAIN  | all requests issued, waiting for the remaining responses
  // FLUSH  | discarding responses, then resetting the FIFO once nothing is in flight
  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_FLUSH} state_t;

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CMAX = CW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_nx;
  logic [CW-1:0]         credits_q, credits_nx;
  logic [OW-1:0]         outstanding_q, outstanding_nx;
  logic                  req_valid_nx, w_en_nx, rstfifo_nx, done_nx;
  logic                  fire, rsp_take;

  assign fire     = req_valid & req_ready;
  assign rsp_take = rsp_valid & (outstanding_q != '0);
  assign busy     = (state != S_IDLE);
  assign req_addr = addr_q;

  always_comb begin
    state_nx       = state;
    addr_nx        = fire ? addr_q + ADDR_INC : addr_q;
    remaining_nx   = (fire && remaining_q != '0) ? remaining_q - LEN_WIDTH'(1) : remaining_q;
    credits_nx     = credits_q;
    outstanding_nx = outstanding_q;
    w_en_nx        = rsp_take && (state != S_FLUSH);
    rstfifo_nx     = 1'b0;
    done_nx        = 1'b0;
    req_valid_nx   = 1'b0;

    // a word occupies a credit from request fire until the consumer pops it
    if (fire && !fifo_pop) begin
      if (credits_q != '0) credits_nx = credits_q - CW'(1);
    end else if (!fire && fifo_pop && credits_q != CMAX) begin
      credits_nx = credits_q + CW'(1);
    end

    if (fire && !rsp_take)      outstanding_nx = outstanding_q + OW'(1);
    else if (!fire && rsp_take) outstanding_nx = outstanding_q - OW'(1);

    case (state)
      S_IDLE: begin
        if (cfg_flush) begin
          rstfifo_nx   = 1'b1;
          credits_nx   = CMAX;
          remaining_nx = '0;
        end else if (cfg_start) begin
          if (cfg_len != '0) begin
            addr_nx      = cfg_addr;
            remaining_nx = cfg_len;
            state_nx     = S_BURST;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (cfg_flush) begin
          state_nx     = S_FLUSH;
          remaining_nx = '0;
        end else if (fire && remaining_q == LEN_WIDTH'(1)) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cfg_flush) begin
          state_nx = S_FLUSH;
        end else if (outstanding_q == '0) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_FLUSH: begin
        remaining_nx = '0;
        // a request still held un-accepted must be accepted and answered first
        if (outstanding_q == '0 && !req_valid) begin
          rstfifo_nx = 1'b1;
          credits_nx = CMAX;
          state_nx   = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // request valid is derived from the counters as they will stand next cycle
    if (state_nx == S_BURST)
      req_valid_nx = (remaining_nx != '0) && (credits_nx != '0) && (outstanding_nx < OMAX);
    else if (state_nx == S_FLUSH)
      req_valid_nx = req_valid && !req_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      credits_q     <= CMAX;
      outstanding_q <= '0;
      req_valid     <= 1'b0;
      fifo_w_en     <= 1'b0;
      fifo_wdata    <= '0;
      fifo_rstfifo  <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      addr_q        <= addr_nx;
      remaining_q   <= remaining_nx;
      credits_q     <= credits_nx;
      outstanding_q <= outstanding_nx;
      req_valid     <= req_valid_nx;
      fifo_w_en     <= w_en_nx;
      if (w_en_nx) fifo_wdata <= rsp_data;
      fifo_rstfifo  <= rstfifo_nx;
      done          <= done_nx;
    end
  end

`ifdef PREFETCH_OVF_CHECK_EN
  logic credit_udf, credit_ovf;
  assign credit_udf = fire && !fifo_pop && (credits_q == '0);
  assign credit_ovf = fifo_pop && !fire && (credits_q == CMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_err <= 1'b0;
    else if ((fifo_w_en && fifo_full) || credit_udf || credit_ovf)
      ovf_err <= 1'b1;
    else if (cfg_start)
      ovf_err <= 1'b0;
  end
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
`endif

endmodule

// File: tb/tb_fifo_prefetch_filler.sv
// Randomized bench for fifo_prefetch_filler: memory and FIFO are modelled with queues,
// expected addresses/data/pulse counts come from the burst rules, not from the RTL.
module tb_fifo_prefetch_filler;
  localparam int AW = 32, DW = 32, LW = 16, DEPTH = 9, MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, cfg_flush;
  logic [AW-1:0] cfg_addr;
  logic [LW-1:0] cfg_len;
  logic          busy, done, req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          fifo_w_en, fifo_rstfifo, fifo_pop, fifo_full;
  logic [DW-1:0] fifo_wdata;
`ifdef PREFETCH_OVF_CHECK_EN
  logic          ovf_err;
`endif

  fifo_prefetch_filler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .cfg_flush(cfg_flush), .busy(busy), .done(done), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fifo_w_en(fifo_w_en),
    .fifo_wdata(fifo_wdata), .fifo_rstfifo(fifo_rstfifo), .fifo_pop(fifo_pop), .fifo_full(fifo_full)
`ifdef PREFETCH_OVF_CHECK_EN
    , .ovf_err(ovf_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1, rdy_prob = 100, rdy_hold = 0;
  bit pop_en = 1'b0;
  int pop_prob = 100, pop_budget = -1;
  int n_fire, n_write, n_done, n_rst, fifo_cnt = 0, last_due = 0, peak = 0;
  bit flushed = 1'b0;
  logic [AW-1:0] exp_addr, last_addr, prev_addr;
  bit prev_valid = 1'b0, prev_ready = 1'b0;
  int due_q[$];
  logic [DW-1:0] dat_q[$];
  logic [DW-1:0] exp_q[$];

  // One clock of the environment: observe outputs, then drive inputs for the next edge.
  task automatic step();
    bit do_pop;
    int due;
    logic [DW-1:0] d;
    @(negedge clk);
    cyc++;
    cfg_start = 1'b0;
    cfg_flush = 1'b0;
    if (prev_valid && !prev_ready && !rst) begin
      n_cmp++;
      if (req_valid !== 1'b1 || req_addr !== prev_addr) begin
        n_err++; $display("FAIL hold: valid=%b addr=%h want valid=1 addr=%h", req_valid, req_addr, prev_addr);
      end
    end
    if (fifo_w_en === 1'b1) begin
      n_write++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL unexpected_write: data=%h want no write", fifo_wdata);
      end else begin
        d = exp_q.pop_front();
        if (fifo_wdata !== d) begin n_err++; $display("FAIL wdata: got %h want %h", fifo_wdata, d); end
      end
      n_cmp++;
      if (fifo_cnt >= DEPTH - 1) begin n_err++; $display("FAIL overfill: fifo count %0d want < %0d", fifo_cnt, DEPTH - 1); end
    end
    if (done === 1'b1) begin
      n_done++;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL done_busy: busy=%b want 0", busy); end
    end
    if (fifo_rstfifo === 1'b1) begin
      n_rst++;
      n_cmp++;
      if (due_q.size() != 0) begin n_err++; $display("FAIL early_rstfifo: %0d in flight want 0", due_q.size()); end
    end
    do_pop = pop_en && fifo_cnt > 0 && pop_budget != 0 && fifo_rstfifo !== 1'b1 &&
             (int'($urandom_range(99)) < pop_prob);
    if (do_pop && pop_budget > 0) pop_budget--;
    if (fifo_rstfifo === 1'b1) fifo_cnt = 0;
    else fifo_cnt = fifo_cnt + ((fifo_w_en === 1'b1) ? 1 : 0) - (do_pop ? 1 : 0);
    fifo_pop  = do_pop;
    fifo_full = (fifo_cnt >= DEPTH - 1);
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      due = due_q.pop_front();
      d = dat_q.pop_front();
      rsp_valid = 1'b1;
      rsp_data = d;
      if (!flushed) exp_q.push_back(d);
    end else begin
      rsp_valid = 1'b0;
      rsp_data = $urandom;
    end
    if (rdy_hold > 0) begin req_ready = 1'b0; rdy_hold--; end
    else req_ready = (int'($urandom_range(99)) < rdy_prob);
    if (req_valid === 1'b1 && req_ready) begin
      n_fire++;
      last_addr = req_addr;
      n_cmp++;
      if (req_addr !== exp_addr) begin n_err++; $display("FAIL req_addr: got %h want %h", req_addr, exp_addr); end
      exp_addr = exp_addr + 32'd4;
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
      dat_q.push_back($urandom);
    end
    if (due_q.size() > peak) peak = due_q.size();
    n_cmp++;
    if (due_q.size() > MAXO) begin n_err++; $display("FAIL outstanding: %0d in flight want <= %0d", due_q.size(), MAXO); end
    prev_valid = (req_valid === 1'b1);
    prev_ready = req_ready;
    prev_addr  = req_addr;
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input int len);
    step();
    cfg_start = 1'b1; cfg_addr = a; cfg_len = LW'(len);
    exp_addr = a; n_fire = 0; n_write = 0; n_done = 0; n_rst = 0; flushed = 1'b0; peak = 0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin step(); k++; end
    repeat (4) step();
  endtask

  task automatic settle();
    pop_en = 1'b1; pop_prob = 100; pop_budget = -1; rdy_prob = 100;
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, req_valid, fifo_w_en, fifo_rstfifo} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000", {busy, done, req_valid, fifo_w_en, fifo_rstfifo});
    end
    n_cmp++;
    if (req_addr !== '0 || fifo_wdata !== '0) begin
      n_err++; $display("FAIL reset_buses: addr=%h wdata=%h want 0", req_addr, fifo_wdata);
    end
    rst = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b0 || req_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b valid=%b want 0", busy, req_valid); end
  endtask

  task automatic test_basic();
    settle();
    lat_min = 2; lat_max = 2;
    start_burst(32'h1000, 4);
    wait_done(100);
    n_cmp++;
    if (n_fire != 4 || n_write != 4) begin n_err++; $display("FAIL basic_count: fires=%0d writes=%0d want 4/4", n_fire, n_write); end
    n_cmp++;
    if (n_done != 1) begin n_err++; $display("FAIL basic_done: got %0d pulses want 1", n_done); end
    n_cmp++;
    if (last_addr !== 32'h100C) begin n_err++; $display("FAIL basic_last_addr: got %h want 0000100c", last_addr); end
  endtask

  task automatic test_zero_len();
    settle();
    start_burst(32'h1234_0000, 0);
    step();
    n_cmp++;
    if (n_done != 1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_done: pulses=%0d busy=%b want 1/0", n_done, busy); end
    repeat (5) step();
    n_cmp++;
    if (n_done != 1 || n_fire != 0) begin n_err++; $display("FAIL zero_quiet: pulses=%0d fires=%0d want 1/0", n_done, n_fire); end
  endtask

  task automatic test_wrap();
    settle();
    lat_min = 1; lat_max = 3;
    start_burst(32'hFFFF_FFFC, 2);
    wait_done(100);
    n_cmp++;
    if (n_fire != 2 || last_addr !== 32'h0) begin n_err++; $display("FAIL wrap: fires=%0d last=%h want 2/00000000", n_fire, last_addr); end
  endtask

  task automatic test_stall();
    settle();
    lat_min = 1; lat_max = 2;
    start_burst(32'h2000, 3);
    rdy_hold = 1000;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (req_valid !== 1'b1 || req_addr !== 32'h2000) begin
        n_err++; $display("FAIL stall_%0d: valid=%b addr=%h want 1/00002000", i, req_valid, req_addr);
      end
    end
    rdy_hold = 0;
    wait_done(100);
    n_cmp++;
    if (n_fire != 3 || n_write != 3 || n_done != 1) begin
      n_err++; $display("FAIL stall_end: fires=%0d writes=%0d done=%0d want 3/3/1", n_fire, n_write, n_done);
    end
  endtask

  task automatic test_credit();
    settle();
    lat_min = 1; lat_max = 3; pop_en = 1'b0;
    start_burst(32'h8000, 20);
    repeat (60) step();
    n_cmp++;
    if (n_fire != DEPTH - 1 || req_valid !== 1'b0) begin
      n_err++; $display("FAIL credit_stop: fires=%0d valid=%b want %0d/0", n_fire, req_valid, DEPTH - 1);
    end
    n_cmp++;
    if (fifo_cnt != DEPTH - 1) begin n_err++; $display("FAIL credit_fill: fifo=%0d want %0d", fifo_cnt, DEPTH - 1); end
    pop_en = 1'b1; pop_budget = 3;
    repeat (40) step();
    n_cmp++;
    if (n_fire != DEPTH + 2) begin n_err++; $display("FAIL credit_pop3: fires=%0d want %0d", n_fire, DEPTH + 2); end
    pop_budget = -1;
    wait_done(300);
    n_cmp++;
    if (n_fire != 20 || n_write != 20 || n_done != 1) begin
      n_err++; $display("FAIL credit_end: fires=%0d writes=%0d done=%0d want 20/20/1", n_fire, n_write, n_done);
    end
  endtask

  task automatic test_outstanding();
    settle();
    lat_min = 10; lat_max = 10;
    start_burst(32'h0000_4000, 12);
    wait_done(400);
    n_cmp++;
    if (peak != MAXO) begin n_err++; $display("FAIL peak_outstanding: got %0d want %0d", peak, MAXO); end
    n_cmp++;
    if (n_fire != 12 || n_write != 12 || n_done != 1) begin
      n_err++; $display("FAIL outst_end: fires=%0d writes=%0d done=%0d want 12/12/1", n_fire, n_write, n_done);
    end
  endtask

  task automatic test_flush();
    int k = 0;
    settle();
    lat_min = 10; lat_max = 10;
    start_burst(32'h3000, 3);
    while (n_fire < 3 && k < 30) begin step(); k++; end
    step();
    n_cmp++;
    if (due_q.size() != 3) begin n_err++; $display("FAIL flush_inflight: got %0d want 3", due_q.size()); end
    cfg_flush = 1'b1;
    flushed = 1'b1;
    k = 0;
    while (n_rst == 0 && k < 40) begin step(); k++; end
    repeat (5) step();
    n_cmp++;
    if (n_rst != 1 || n_done != 0 || n_write != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush: rst=%0d done=%0d writes=%0d busy=%b want 1/0/0/0", n_rst, n_done, n_write, busy);
    end
    // with no pops, a full-capacity burst only completes if credits were restored
    lat_min = 1; lat_max = 4; pop_en = 1'b0;
    start_burst(32'h5000, DEPTH - 1);
    wait_done(150);
    n_cmp++;
    if (n_fire != DEPTH - 1 || n_write != DEPTH - 1 || n_done != 1) begin
      n_err++; $display("FAIL post_flush: fires=%0d writes=%0d done=%0d want %0d/%0d/1", n_fire, n_write, n_done, DEPTH - 1, DEPTH - 1);
    end
  endtask

  task automatic test_random();
    int len;
    for (int b = 0; b < 6; b++) begin
      settle();
      rdy_prob = 60; lat_min = 1; lat_max = 6; pop_prob = 50;
      len = int'($urandom_range(15, 1));
      start_burst($urandom & 32'hFFFF_FFFC, len);
      wait_done(800);
      n_cmp++;
      if (n_fire != len || n_write != len || n_done != 1) begin
        n_err++; $display("FAIL random_%0d: fires=%0d writes=%0d done=%0d want %0d/%0d/1", b, n_fire, n_write, n_done, len, len);
      end
    end
  endtask

  task automatic test_rst_mid();
    int k = 0;
    settle();
    lat_min = 10; lat_max = 10;
    start_burst(32'h6000, 6);
    while (n_fire < 3 && k < 30) begin step(); k++; end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, req_valid, fifo_w_en, done, fifo_rstfifo} !== 5'b0 || req_addr !== '0) begin
      n_err++; $display("FAIL rst_mid: flags=%b addr=%h want 0", {busy, req_valid, fifo_w_en, done, fifo_rstfifo}, req_addr);
    end
    flushed = 1'b1; prev_valid = 1'b0; fifo_cnt = 0; exp_q.delete(); n_write = 0;
    step();
    rst = 1'b0;
    k = 0;
    while (due_q.size() > 0 && k < 40) begin step(); k++; end
    repeat (3) step();
    n_cmp++;
    if (n_write != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_late_rsp: writes=%0d busy=%b want 0/0", n_write, busy); end
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_flush = 1'b0; cfg_addr = '0; cfg_len = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; fifo_pop = 1'b0; fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_stall();
    test_credit();
    test_outstanding();
    test_flush();
    test_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
